isqrt_iter_fsm: RTL and testbench
=================================

# isqrt_iter_fsm

Iterative integer square root, y = floor(sqrt(x)), computed one result bit per clock by a digit-by-digit state machine. It is the responder side of the isqrt valid-handshake that the sqrt-formula FSMs drive: those FSMs issue `x_vld`/`x` and wait for `y_vld`/`y`. This block trades throughput for area against the pipelined isqrt. It is intended for sequential formula implementations that issue at most one outstanding request.

## Interface

Parameters:
- `n`, default 32: input width. Must be even and ≥ 4. Result width is n/2.

Ports:
- `clk` input 1: clock; single clock domain.
- `rst` input 1: reset, asynchronous and active-high.
- `x_vld` input 1: request strobe, one cycle per request.
- `x` input n: unsigned radicand; sampled only when the request is accepted.
- `x_rdy` output 1: block can accept a request this cycle.
- `y_vld` output 1: one-cycle pulse; `y` is valid.
- `y` output n/2: floor(sqrt(x)); held until the next result.
- `overrun` output 1: sticky; set when `x_vld` arrives while `x_rdy` is 0.

## Operation

- States (enum in package): `IDLE`, `CALC`, `DONE`.
- IDLE: `x_rdy`=1. On `x_vld`:
  - load operand shift register ← `x`, rem ← 0, root ← 0, step counter ← n/2−1;
  - go to CALC.
- CALC: one step per cycle.
  - rem' = (rem << 2) | (two MSBs of operand); operand <<= 2.
  - trial = (root << 2) | 1.
  - If rem' ≥ trial: rem ← rem' − trial, root ← (root << 1) | 1.
  - Else: rem ← rem', root ← root << 1.
  - When counter = 0: y ← final root, go to DONE. Otherwise counter decrements.
- DONE: `y_vld`=1 and `x_rdy`=1 for exactly one cycle.
  - A new `x_vld` in this cycle is accepted and goes straight to CALC.
  - Otherwise go to IDLE.
- Width rules:
  - rem is n/2+2 bits; root is n/2 bits; counter is $clog2(n/2) bits.
  - No truncation is permitted; comparison and subtraction are unsigned.
- Busy request: `x_vld` in CALC is ignored. The operation in flight is unaffected, and `overrun` is set to 1 and stays 1 until `rst`.
- Final remainder is internal only, not exported.

## Timing

- Reset values:
  - `x_rdy`=1, `y_vld`=0, `y`=0, `overrun`=0.
  - State IDLE; all internal registers 0.
- Latency: `x_vld` accepted at edge E → CALC occupies cycles E+1 … E+n/2 → `y_vld` high in cycle E+n/2+1. That is n/2+1 cycles; 17 for n=32.
- Throughput: one result per n/2+1 cycles when requests arrive in each DONE cycle.
- `y` updates on the same edge that raises `y_vld`. It is stable through the pulse and until the next DONE.
- `x_rdy` is a registered function of state only; it has no combinational path from `x_vld`.
- `rst` mid-CALC aborts immediately:
  - all outputs return to reset values;
  - no `y_vld` is produced for the aborted request.
- `x_vld` coincident with `rst` deassertion edge: not accepted (reset wins).

## Structure

- Package `isqrt_iter_pkg`:
  - `state_t` enum (IDLE, CALC, DONE);
  - width helper functions for n/2 and n/2+2.
- Sub-module `isqrt_iter_step`: combinational single iteration, (rem, root, two operand bits) → (rem_next, root_next).
  - Top holds the FSM, counter and registers.
  - The step sub-module is reusable by an unrolled or pipelined variant.

## Test plan

- n=32, reset then `x`=0 → `y_vld` exactly 17 cycles after acceptance, `y`=0, `overrun`=0.
- Perfect and non-perfect squares:
  - `x`=16 → 4; `x`=15 → 3; `x`=1 → 1;
  - `x`=0xFFFF_FFFF → 0xFFFF; `x`=0xFFFE_0001 → 0xFFFF.
- Back-to-back: `x`=100 (→10), then a new `x_vld` with `x`=81 in the DONE cycle → accepted, second `y_vld` 17 cycles after the first with `y`=9.
- Busy: `x_vld` with `x`=49 during CALC of `x`=144 → `y`=12 only, no second `y_vld`, `overrun`=1 until reset.
- Reset mid-CALC (cycle 8 of 16) → no `y_vld`, `y`=0, `x_rdy`=1; the next request `x`=225 → 15 with normal latency.
- Random sweep: 1000 random 32-bit `x` compared against a software floor(sqrt) model; also n=8 exhaustive over 0…255.

Source files
------------

// File: rtl/isqrt_iter_pkg.sv
// Shared types and width helpers for the iterative integer square root.
package isqrt_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result width: one root bit per pair of radicand bits.
  function automatic int half_w(input int n);
    return n / 2;
  endfunction

  // Partial remainder width: never exceeds 2*root, plus headroom for the shift-in.
  function automatic int rem_w(input int n);
    return n / 2 + 2;
  endfunction

endpackage

// File: rtl/isqrt_iter_step.sv
// One digit-by-digit square-root iteration: brings in two radicand bits and
// decides the next root bit. Purely combinational so it can be replicated.
module isqrt_iter_step
  import isqrt_iter_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [rem_w(n)-1:0]  rem,
  input  logic [half_w(n)-1:0] root,
  input  logic [1:0]           bits,
  output logic [rem_w(n)-1:0]  rem_next,
  output logic [half_w(n)-1:0] root_next
);

  localparam int HW = half_w(n);
  localparam int RW = rem_w(n);

  logic [RW+1:0] rem_sh;
  logic [RW+1:0] trial;
  logic          ge;

  // Work two bits wider than rem so the shift-in and compare are exact.
  assign rem_sh = {rem, bits};
  assign trial  = {2'b00, root, 2'b01};
  assign ge     = (rem_sh >= trial);

  // The dropped upper bits are provably zero: rem stays below 2^(RW) by construction.
  assign rem_next  = RW'(ge ? (rem_sh - trial) : rem_sh);
  assign root_next = HW'({root, ge});

endmodule

// File: rtl/isqrt_iter_fsm.sv
// Iterative floor(sqrt(x)): one result bit per clock, valid handshake on both
// sides, one request in flight at a time.
module isqrt_iter_fsm
  import isqrt_iter_pkg::*;
#(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           x_vld,
  input  logic [n-1:0]   x,
  output logic           x_rdy,
  output logic           y_vld,
  output logic [n/2-1:0] y,
  output logic           overrun
);

  localparam int HW = half_w(n);
  localparam int RW = rem_w(n);
  localparam int CW = $clog2(HW);

  state_t          state;
  state_t          state_next;
  logic [n-1:0]    opnd;
  logic [RW-1:0]   rem;
  logic [RW-1:0]   rem_next;
  logic [HW-1:0]   root;
  logic [HW-1:0]   root_next;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last;

  assign accept = x_vld && x_rdy;
  assign last   = (cnt == '0);

  isqrt_iter_step #(.n(n)) u_step (
    .rem       (rem),
    .root      (root),
    .bits      (opnd[n-1 -: 2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (x_vld) state_next = CALC;
      CALC:    if (last)  state_next = DONE;
      DONE:    state_next = x_vld ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only; x_vld never reaches them.
  always_comb begin
    x_rdy = (state != CALC);
    y_vld = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd <= '0;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
      y    <= '0;
    end else if (accept) begin
      opnd <= x;
      rem  <= '0;
      root <= '0;
      cnt  <= CW'(HW - 1);
    end else if (state == CALC) begin
      opnd <= {opnd[n-3:0], 2'b00};
      rem  <= rem_next;
      root <= root_next;
      cnt  <= cnt - CW'(1);
      if (last) y <= root_next;
    end
  end

  // Requests dropped while busy are flagged until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 overrun <= 1'b0;
    else if (x_vld && !x_rdy) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Randomized and directed bench for isqrt_iter_fsm (n=32 and n=8) against a
// binary-search floor(sqrt) reference.
module tb_isqrt_iter_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        x_vld;
  logic [31:0] x;
  logic        x_rdy;
  logic        y_vld;
  logic [15:0] y;
  logic        overrun;

  logic        x_vld8;
  logic [7:0]  x8;
  logic        x_rdy8;
  logic        y_vld8;
  logic [3:0]  y8;
  logic        overrun8;

  int unsigned cyc = 0;
  int unsigned t_req = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  isqrt_iter_fsm #(.n(32)) dut (
    .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .x_rdy(x_rdy),
    .y_vld(y_vld), .y(y), .overrun(overrun)
  );

  isqrt_iter_fsm #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .x_vld(x_vld8), .x(x8), .x_rdy(x_rdy8),
    .y_vld(y_vld8), .y(y8), .overrun(overrun8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Largest r with r*r <= v, found by bisection.
  function automatic longint unsigned ref_isqrt(input longint unsigned v);
    longint unsigned lo = 0;
    longint unsigned hi = 65536;
    longint unsigned mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid;
      else                hi = mid;
    end
    return lo;
  endfunction

  task automatic issue32(input logic [31:0] v);
    for (int i = 0; i < 40 && !x_rdy; i++) @(negedge clk);
    if (!x_rdy) check("rdy_timeout", x_rdy, 1);
    x_vld = 1'b1;
    x     = v;
    t_req = cyc;
    @(negedge clk);
    x_vld = 1'b0;
  endtask

  task automatic wait_y32(output bit seen, output int lat);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (y_vld) seen = 1'b1;
      else       @(negedge clk);
    end
    lat = int'(cyc - t_req);
  endtask

  task automatic xact32(input string tag, input logic [31:0] v);
    bit seen;
    int lat;
    issue32(v);
    wait_y32(seen, lat);
    check({tag, "_seen"}, seen, 1);
    check({tag, "_lat"}, lat, 17);
    check({tag, "_y"}, y, ref_isqrt(v));
  endtask

  task automatic xact8(input logic [7:0] v);
    bit seen = 1'b0;
    int lat;
    for (int i = 0; i < 20 && !x_rdy8; i++) @(negedge clk);
    x_vld8 = 1'b1;
    x8     = v;
    t_req  = cyc;
    @(negedge clk);
    x_vld8 = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (y_vld8) seen = 1'b1;
      else        @(negedge clk);
    end
    lat = int'(cyc - t_req);
    check("n8_seen", seen, 1);
    check("n8_lat", lat, 5);
    check("n8_y", y8, ref_isqrt(v));
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (y_vld) pulses++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int lat;
    int pulses;
    logic [31:0] dir_x [5] = '{32'd16, 32'd15, 32'd1, 32'hFFFF_FFFF, 32'hFFFE_0001};

    x_vld  = 1'b0;
    x      = '0;
    x_vld8 = 1'b0;
    x8     = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_x_rdy", x_rdy, 1);
    check("rst_y_vld", y_vld, 0);
    check("rst_y", y, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    xact32("zero", 32'd0);
    check("zero_overrun", overrun, 0);

    foreach (dir_x[i]) xact32($sformatf("dir%0d", i), dir_x[i]);

    // Back-to-back: second request lands in the DONE cycle of the first.
    issue32(32'd100);
    wait_y32(seen, lat);
    check("b2b1_lat", lat, 17);
    check("b2b1_y", y, 10);
    check("b2b_rdy_in_done", x_rdy, 1);
    x_vld = 1'b1;
    x     = 32'd81;
    t_req = cyc;
    @(negedge clk);
    x_vld = 1'b0;
    wait_y32(seen, lat);
    check("b2b2_seen", seen, 1);
    check("b2b2_lat", lat, 17);
    check("b2b2_y", y, 9);

    // Busy request is dropped and flags overrun.
    issue32(32'd144);
    repeat (3) @(negedge clk);
    check("busy_x_rdy", x_rdy, 0);
    x_vld = 1'b1;
    x     = 32'd49;
    @(negedge clk);
    x_vld = 1'b0;
    check("busy_overrun_set", overrun, 1);
    wait_y32(seen, lat);
    check("busy_lat", lat, 17);
    check("busy_y", y, 12);
    count_pulses(30, pulses);
    check("busy_no_second", pulses, 0);
    check("busy_overrun_sticky", overrun, 1);
    check("busy_y_held", y, 12);

    // Reset in the 8th CALC cycle aborts the operation.
    issue32(32'd200);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_y", y, 0);
    check("abort_x_rdy", x_rdy, 1);
    check("abort_y_vld", y_vld, 0);
    check("abort_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    count_pulses(30, pulses);
    check("abort_no_y_vld", pulses, 0);
    xact32("after_rst", 32'd225);

    for (int i = 0; i < 1000; i++) xact32("rand", $urandom());

    for (int v = 0; v < 256; v++) xact8(v[7:0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
